sprite_move_sched: RTL and testbench

//  Time-shares one bounce-step datapath among NUM_SPR sprites; replaces one bounce-mover instance per sprite.

---
 rtl/sprite_move_sched_pkg.sv | 11 +
 rtl/sprite_move_sched_bounce_axis.sv | 28 ++
 rtl/sprite_move_sched.sv | 114 +++++++++++
 tb/tb_sprite_move_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_move_sched_pkg.sv
// sprite_move_sched_pkg: shared screen defaults, direction codes and FSM encoding for the sprite scheduler.
package sprite_move_sched_pkg;
  localparam int H_SIZE_DEF = 640;
  localparam int V_SIZE_DEF = 480;
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sprite_move_sched_bounce_axis.sv
// sprite_move_sched_bounce_axis: one-axis bounce step, combinational, evaluated one bit wider than the position.
module sprite_move_sched_bounce_axis
  import sprite_move_sched_pkg::*;
#(
  parameter int W     = 10,
  parameter int LIMIT = 540,
  parameter int STEP  = 1
) (
  input  logic [W-1:0] pos_i,
  input  logic         dir_i,
  output logic [W-1:0] npos_o,
  output logic         ndir_o
);
  logic [W:0] ext, lim, stp, sum, dif, nxt;
  logic       fwd, hit;
  always_comb begin
    ext    = {1'b0, pos_i};
    lim    = (W+1)'(LIMIT);
    stp    = (W+1)'(STEP);
    sum    = ext + stp;
    dif    = ext - stp;
    fwd    = dir_i == DIR_POS;
    hit    = fwd ? (sum >= lim) : (ext <= stp);
    nxt    = hit ? (fwd ? lim : '0) : (fwd ? sum : dif);
    npos_o = W'(nxt);
    ndir_o = hit ? (fwd ? DIR_NEG : DIR_POS) : dir_i;
  end
endmodule

// File: rtl/sprite_move_sched.sv
// sprite_move_sched: divides scan-derived frame ends and sweeps one shared bounce datapath across all sprites, one per clock.
module sprite_move_sched
  import sprite_move_sched_pkg::*;
#(
  parameter int NUM_SPR   = 4,
  parameter int H_SIZE    = H_SIZE_DEF,
  parameter int V_SIZE    = V_SIZE_DEF,
  parameter int PIC_H     = 100,
  parameter int PIC_V     = 100,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1,
  localparam int XW = $clog2(H_SIZE),
  localparam int YW = $clog2(V_SIZE),
  localparam int IW = clog2_min1(NUM_SPR)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [XW-1:0]         h_addr_i,
  input  logic [YW-1:0]         v_addr_i,
  input  logic                  cfg_we_i,
  input  logic [IW-1:0]         cfg_idx_i,
  input  logic [XW-1:0]         cfg_x_i,
  input  logic [YW-1:0]         cfg_y_i,
  input  logic                  cfg_dx_i,
  input  logic                  cfg_dy_i,
  output logic                  cfg_ready_o,
  output logic [NUM_SPR*XW-1:0] pos_x_o,
  output logic [NUM_SPR*YW-1:0] pos_y_o,
  output logic                  busy_o,
  output logic                  upd_done_o,
  output logic                  overrun_o
);
  localparam int XMAX = H_SIZE - PIC_H;
  localparam int YMAX = V_SIZE - PIC_V;
  localparam int DW   = clog2_min1(FRAME_DIV);
  state_e               state_q;
  logic [IW-1:0]        idx_q;
  logic [DW-1:0]        div_q;
  logic [XW-1:0]        px_q [NUM_SPR];
  logic [YW-1:0]        py_q [NUM_SPR];
  logic [NUM_SPR-1:0]   dx_q, dy_q;
  logic                 busy_q, done_q, ovr_q;
  logic                 frame_end, tick, due, cfg_ok, last;
  logic [XW-1:0]        cfg_xc, nx;
  logic [YW-1:0]        cfg_yc, ny;
  logic                 ndx, ndy;
  assign frame_end   = (h_addr_i == XW'(H_SIZE-1)) && (v_addr_i == YW'(V_SIZE-1));
  assign tick        = frame_end && enable_i;
  assign due         = tick && (div_q == DW'(FRAME_DIV-1));
  assign cfg_ready_o = state_q == IDLE;
  assign cfg_ok      = cfg_we_i && cfg_ready_o;
  assign cfg_xc      = (cfg_x_i > XW'(XMAX)) ? XW'(XMAX) : cfg_x_i;
  assign cfg_yc      = (cfg_y_i > YW'(YMAX)) ? YW'(YMAX) : cfg_y_i;
  assign last        = idx_q == IW'(NUM_SPR-1);
  assign busy_o      = busy_q;
  assign upd_done_o  = done_q;
  assign overrun_o   = ovr_q;
  sprite_move_sched_bounce_axis #(.W(XW), .LIMIT(XMAX), .STEP(STEP)) u_x (
    .pos_i(px_q[idx_q]), .dir_i(dx_q[idx_q]), .npos_o(nx), .ndir_o(ndx)
  );
  sprite_move_sched_bounce_axis #(.W(YW), .LIMIT(YMAX), .STEP(STEP)) u_y (
    .pos_i(py_q[idx_q]), .dir_i(dy_q[idx_q]), .npos_o(ny), .ndir_o(ndy)
  );
  for (genvar i = 0; i < NUM_SPR; i++) begin : g_pack
    assign pos_x_o[i*XW +: XW] = px_q[i];
    assign pos_y_o[i*YW +: YW] = py_q[i];
  end
  // Config writes only land in IDLE, so they never collide with the sweep write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      for (int i = 0; i < NUM_SPR; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (tick) div_q <= due ? '0 : div_q + 1'b1;
      if (cfg_ok) begin
        px_q[cfg_idx_i] <= cfg_xc;
        py_q[cfg_idx_i] <= cfg_yc;
        dx_q[cfg_idx_i] <= cfg_dx_i;
        dy_q[cfg_idx_i] <= cfg_dy_i;
      end
      if (state_q == IDLE) begin
        if (due) begin
          state_q <= SWEEP;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      end else begin
        px_q[idx_q] <= nx;
        py_q[idx_q] <= ny;
        dx_q[idx_q] <= ndx;
        dy_q[idx_q] <= ndy;
        idx_q       <= idx_q + 1'b1;
        if (due) ovr_q <= 1'b1;
        if (last) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sprite_move_sched.sv
// tb_sprite_move_sched: random and directed stimulus against a whole-sweep reference model, checked through scoreboard queues.
module tb_sprite_move_sched;
  localparam int NS = 4, H = 640, V = 480, PH = 100, PV = 100, ST = 3, FD = 2;
  localparam int XW = $clog2(H), YW = $clog2(V), IW = $clog2(NS);
  localparam int XMAX = H - PH, YMAX = V - PV;
  logic clk = 0, rst_n = 0, en = 0, we = 0, dxi = 0, dyi = 0;
  logic [XW-1:0] h = 0, cx = 0;
  logic [YW-1:0] v = 0, cy = 0;
  logic [IW-1:0] ci = 0;
  logic rdy, busy, done, ovr;
  logic [NS*XW-1:0] px;
  logic [NS*YW-1:0] py;
  sprite_move_sched #(
    .NUM_SPR(NS), .H_SIZE(H), .V_SIZE(V), .PIC_H(PH), .PIC_V(PV), .STEP(ST), .FRAME_DIV(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .h_addr_i(h), .v_addr_i(v),
    .cfg_we_i(we), .cfg_idx_i(ci), .cfg_x_i(cx), .cfg_y_i(cy), .cfg_dx_i(dxi), .cfg_dy_i(dyi),
    .cfg_ready_o(rdy), .pos_x_o(px), .pos_y_o(py), .busy_o(busy), .upd_done_o(done), .overrun_o(ovr)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [NS*XW-1:0] x;
    logic [NS*YW-1:0] y;
  } snap_t;
  snap_t sq[$];
  logic [3:0] cq[$];
  int checks = 0, failures = 0;
  int mx[NS], my[NS], mdiv = 0, mcnt = 0;
  bit mdx[NS], mdy[NS], mdone = 0, movr = 0;
  logic [3:0] e;
  snap_t s;
  function automatic void bounce(inout int p, inout bit d, input int lim);
    if (!d) begin
      if (p + ST >= lim) begin p = lim; d = 1; end
      else p = p + ST;
    end else begin
      if (p <= ST) begin p = 0; d = 0; end
      else p = p - ST;
    end
  endfunction
  function automatic snap_t pack_model();
    snap_t r;
    for (int i = 0; i < NS; i++) begin
      r.x[i*XW +: XW] = XW'(mx[i]);
      r.y[i*YW +: YW] = YW'(my[i]);
    end
    return r;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0;
    end
    mdiv = 0; mcnt = 0; mdone = 0; movr = 0;
    sq.delete();
  endtask
  // One clock of stimulus; the model advances a whole sweep at once since config cannot interleave with it.
  task automatic cyc(input bit fe, input bit ena, input bit w, input int idx,
                     input int x, input int y, input bit ddx, input bit ddy);
    bit idle, due, nd;
    @(negedge clk);
    rst_n = 1; en = ena; we = w; ci = IW'(idx); cx = XW'(x); cy = YW'(y); dxi = ddx; dyi = ddy;
    h = fe ? XW'(H-1) : XW'($urandom_range(H-2));
    v = fe ? YW'(V-1) : YW'($urandom_range(V-1));
    cq.push_back({mcnt > 0, mcnt == 0, mdone, movr});
    idle = mcnt == 0;
    nd = mcnt == 1;
    due = 0;
    if (!idle) mcnt--;
    if (w && idle) begin
      mx[idx] = x > XMAX ? XMAX : x;
      my[idx] = y > YMAX ? YMAX : y;
      mdx[idx] = ddx;
      mdy[idx] = ddy;
    end
    if (fe && ena) begin
      if (mdiv == FD-1) begin mdiv = 0; due = 1; end
      else mdiv++;
    end
    if (due && idle) begin
      for (int i = 0; i < NS; i++) begin
        bounce(mx[i], mdx[i], XMAX);
        bounce(my[i], mdy[i], YMAX);
      end
      sq.push_back(pack_model());
      mcnt = NS;
    end else if (due) movr = 1;
    mdone = nd;
  endtask
  task automatic idle_n(input int n);
    repeat (n) cyc(0, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic fe_n(input int n, input bit ena);
    repeat (n) begin cyc(1, ena, 0, 0, 0, 0, 0, 0); idle_n(6); end
  endtask
  task automatic rst_cyc();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    cq.push_back(4'b0100);
  endtask
  task automatic arm_due();
    if (mdiv != FD-1) fe_n(1, 1);
  endtask
  function automatic int pick(input int mx_lim, input int full);
    case ($urandom_range(3))
      0: return $urandom_range(full);
      1: return mx_lim - $urandom_range(3);
      2: return $urandom_range(ST + 1);
      default: return $urandom_range(mx_lim);
    endcase
  endfunction
  task automatic rand_phase(input int n, input int fe_div, input bit rst_ok);
    repeat (n) begin
      if (rst_ok && $urandom_range(150) == 0) rst_cyc();
      else cyc($urandom_range(fe_div) == 0, $urandom_range(7) != 0, $urandom_range(3) == 0,
               $urandom_range(NS-1), pick(XMAX, (1 << XW) - 1), pick(YMAX, (1 << YW) - 1),
               1'($urandom_range(1)), 1'($urandom_range(1)));
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (cq.size() > 0) begin
        e = cq.pop_front();
        checks++;
        if ({busy, rdy, done, ovr} !== e) begin
          failures++;
          $display("FAIL status t=%0t busy/rdy/done/ovr got=%b want=%b", $time, {busy, rdy, done, ovr}, e);
        end
      end
      if (!rst_n) begin
        checks++;
        if (px !== '0 || py !== '0) begin
          failures++;
          $display("FAIL reset_pos t=%0t got x=%h y=%h want 0", $time, px, py);
        end
      end
      if (done) begin
        checks++;
        if (sq.size() == 0) begin
          failures++;
          $display("FAIL spurious_done t=%0t upd_done=1 with no sweep expected", $time);
        end else begin
          s = sq.pop_front();
          if (px !== s.x || py !== s.y) begin
            failures++;
            $display("FAIL sweep_pos t=%0t got x=%h y=%h want x=%h y=%h", $time, px, py, s.x, s.y);
          end
        end
      end
    end
  end
  initial begin
    model_reset();
    repeat (3) rst_cyc();
    idle_n(3);
    fe_n(2, 1);
    cyc(0, 1, 1, 2, 539, 1, 0, 1);
    fe_n(4, 1);
    cyc(0, 1, 1, 1, 630, 500, 1, 1);
    cyc(0, 1, 1, 0, 2, 3, 1, 1);
    fe_n(2, 1);
    fe_n(5, 0);
    idle_n(2);
    arm_due();
    cyc(1, 1, 1, 3, 537, 2, 0, 1);
    cyc(0, 1, 1, 3, 77, 77, 1, 1);
    idle_n(6);
    rand_phase(600, 7, 0);
    idle_n(6);
    arm_due();
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    idle_n(10);
    arm_due();
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    idle_n(2);
    rst_cyc();
    idle_n(2);
    fe_n(2, 1);
    rand_phase(1200, 3, 1);
    idle_n(8);
    @(negedge clk);
    #2;
    checks++;
    if (sq.size() != 0) begin
      failures++;
      $display("FAIL pending_sweeps got=%0d want=0", sq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
